// File: rtl/state_framer.sv
// Snapshots cracker state at frame start and streams it as a framed byte sequence
// (five headed records, XOR checksum, footer) over a valid/ready byte interface.
module state_framer #(
    parameter int PW_CHARS   = 20,
    parameter int HASH_COUNT = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      continuous,
    input  logic                      frame_req,
    input  logic [4:0]                password_len,
    input  logic [8*PW_CHARS-1:0]     password_chars,
    input  logic [128*HASH_COUNT-1:0] hashes,
    input  logic [127:0]              current_hash,
    input  logic [4:0]                ntcrackfpga_state,
    input  logic [3:0]                hashchecker_state,
    input  logic [5:0]                md4block_step,
    output logic [7:0]                out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy,
    output logic                      frame_done
);
    localparam int FRAME_LEN = 50 + PW_CHARS + 16*HASH_COUNT;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int PW_BITS   = 8*PW_CHARS;
    localparam int HASH_BITS = 128*HASH_COUNT;

    // First index of each region after the record-1 block (indices 0..5)
    localparam int OFS_PW   = 11;
    localparam int OFS_R3   = OFS_PW + PW_CHARS;
    localparam int OFS_HASH = OFS_R3 + 5;
    localparam int OFS_R4   = OFS_HASH + 16*HASH_COUNT;
    localparam int OFS_CUR  = OFS_R4 + 5;
    localparam int OFS_R5   = OFS_CUR + 16;
    localparam int OFS_ST   = OFS_R5 + 5;
    localparam int OFS_CK   = OFS_ST + 3;
    localparam int OFS_FT   = OFS_CK + 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);

    typedef enum logic {IDLE, SEND} state_t;
    state_t state;

    logic [IDX_W-1:0]     idx;
    logic [7:0]           csum;
    logic [4:0]           snap_len;
    logic [PW_BITS-1:0]   snap_pw;
    logic [HASH_BITS-1:0] snap_hash;
    logic [127:0]         snap_cur;
    logic [4:0]           snap_st;
    logic [3:0]           snap_hc;
    logic [5:0]           snap_md;

    logic [PW_BITS-1:0]   pw_sh;
    logic [HASH_BITS-1:0] hash_sh;
    logic [127:0]         cur_sh;
    logic [7:0]           nxt_byte;
    int                   n;

    function automatic logic [7:0] hdr_byte(input int pos, input logic [7:0] id);
        case (pos)
            0:       return 8'h0A;
            1:       return 8'h55;
            2:       return 8'hFA;
            3:       return 8'hCE;
            default: return id;
        endcase
    endfunction

    function automatic logic [7:0] ftr_byte(input int pos);
        case (pos)
            0:       return 8'hA2;
            1:       return 8'h5E;
            2:       return 8'hFA;
            3:       return 8'hCE;
            default: return 8'h00;
        endcase
    endfunction

    // Byte at index idx+1, i.e. the one loaded when the current byte is accepted
    always_comb begin
        n        = int'(idx) + 1;
        pw_sh    = snap_pw   << (8*(n - OFS_PW));
        hash_sh  = snap_hash << (8*(n - OFS_HASH));
        cur_sh   = snap_cur  << (8*(n - OFS_CUR));
        nxt_byte = 8'h00;
        if (n < 5)              nxt_byte = hdr_byte(n, 8'h01);
        else if (n == 5)        nxt_byte = {3'b0, snap_len};
        else if (n < OFS_PW)    nxt_byte = hdr_byte(n - 6, 8'h02);
        else if (n < OFS_R3)    nxt_byte = pw_sh[PW_BITS-1 -: 8];
        else if (n < OFS_HASH)  nxt_byte = hdr_byte(n - OFS_R3, 8'h03);
        else if (n < OFS_R4)    nxt_byte = hash_sh[HASH_BITS-1 -: 8];
        else if (n < OFS_CUR)   nxt_byte = hdr_byte(n - OFS_R4, 8'h04);
        else if (n < OFS_R5)    nxt_byte = cur_sh[127 -: 8];
        else if (n < OFS_ST)    nxt_byte = hdr_byte(n - OFS_R5, 8'h05);
        else if (n == OFS_ST)   nxt_byte = {3'b0, snap_st};
        else if (n == OFS_ST+1) nxt_byte = {4'b0, snap_hc};
        else if (n == OFS_ST+2) nxt_byte = {2'b0, snap_md};
        else if (n == OFS_CK)   nxt_byte = csum ^ out_data;   // fold in the byte being accepted
        else                    nxt_byte = ftr_byte(n - OFS_FT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            idx        <= '0;
            csum       <= 8'h00;
            out_data   <= 8'h00;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            snap_len   <= '0;
            snap_pw    <= '0;
            snap_hash  <= '0;
            snap_cur   <= '0;
            snap_st    <= '0;
            snap_hc    <= '0;
            snap_md    <= '0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (continuous || frame_req) begin
                        snap_len  <= password_len;
                        snap_pw   <= password_chars;
                        snap_hash <= hashes;
                        snap_cur  <= current_hash;
                        snap_st   <= ntcrackfpga_state;
                        snap_hc   <= hashchecker_state;
                        snap_md   <= md4block_step;
                        idx       <= '0;
                        csum      <= 8'h00;
                        out_data  <= 8'h0A;
                        out_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (out_ready) begin
                        if (idx == LAST) begin
                            idx        <= '0;
                            csum       <= 8'h00;
                            out_data   <= 8'h00;
                            out_valid  <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            idx      <= idx + 1'b1;
                            csum     <= csum ^ out_data;
                            out_data <= nxt_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
